// File: rtl/surf_autotrain_seq.sv
// SURF COUT link auto-training sequencer.
// Walks each enabled link through an IDELAY tap / bitslip search until the
// training word is seen, measures the width of the passing eye at that slip,
// loads the eye centre and verifies it. Results are reported per link.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for start_i; results from the last run are held
// SRST   | ISERDES held in reset for 4 cycles (returns every link to slip 0)
// LOAD   | one-cycle IDELAY load strobe for the current link
// WAIT   | settle time after a delay load or a bitslip
// CHECK  | counting consecutive matching training words
// SLIP   | one-cycle bitslip strobe for the current link
// EYE    | decide whether the eye extends to the next tap
// CENTER | compute and apply the centre of the measured eye
// VERIFY | record the result of the check at the centre tap
// NEXT   | move to the next enabled link, or finish the run
module surf_autotrain_seq #(
  parameter int          NCH            = 8,
  parameter logic [31:0] TRAIN_SEQUENCE = 32'hA55A6996,
  parameter int          NSLIP          = 4,
  parameter int          SETTLE         = 16,
  parameter int          LOCK_COUNT     = 8,
  parameter int          TIMEOUT        = 256
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              start_i,
  input  logic [NCH-1:0]    ch_enable_i,
  input  logic [32*NCH-1:0] cout_data_i,
  input  logic [NCH-1:0]    cout_valid_i,
  output logic              iserdes_rst_o,
  output logic [5:0]        idelay_value_o,
  output logic [NCH-1:0]    idelay_load_o,
  output logic [NCH-1:0]    bitslip_o,
  output logic              busy_o,
  output logic              done_o,
  output logic [NCH-1:0]    locked_o,
  output logic [NCH-1:0]    fail_o,
  output logic [2:0]        cur_ch_o
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_SRST   = 4'd1;
  localparam logic [3:0] S_LOAD   = 4'd2;
  localparam logic [3:0] S_WAIT   = 4'd3;
  localparam logic [3:0] S_CHECK  = 4'd4;
  localparam logic [3:0] S_SLIP   = 4'd5;
  localparam logic [3:0] S_EYE    = 4'd6;
  localparam logic [3:0] S_CENTER = 4'd7;
  localparam logic [3:0] S_VERIFY = 4'd8;
  localparam logic [3:0] S_NEXT   = 4'd9;

  // What the current CHECK result means depends on how far training has got.
  localparam logic [1:0] PH_SEARCH = 2'd0;
  localparam logic [1:0] PH_EYE    = 2'd1;
  localparam logic [1:0] PH_VERIFY = 2'd2;

  // Down-counter reload values (counter runs reload..0, so N cycles = N-1).
  localparam logic [15:0] SRST_LD    = 16'd3;
  localparam logic [15:0] SETTLE_LD  = 16'(SETTLE - 1);
  localparam logic [15:0] TIMEOUT_LD = 16'(TIMEOUT - 1);
  localparam logic [15:0] LOCK_LAST  = 16'(LOCK_COUNT - 1);
  localparam logic [7:0]  SLIP_LAST  = 8'(NSLIP - 1);
  localparam logic [5:0]  TAP_MAX    = 6'd63;

  logic [3:0]     state;
  logic [1:0]     phase;
  logic [2:0]     cur_ch;
  logic [NCH-1:0] en_q;
  logic [5:0]     tap;
  logic [7:0]     slip;
  logic [5:0]     eye_start;
  logic [5:0]     eye_end;
  logic [15:0]    timer;
  logic [15:0]    match_cnt;
  logic           chk_pass;
  logic           done_q;
  logic [NCH-1:0] locked_q;
  logic [NCH-1:0] fail_q;

  logic [NCH-1:0] ch_onehot;
  logic           valid_sel;
  logic [31:0]    data_sel;
  logic           check_done;
  logic           check_ok;
  logic [3:0]     first_en;
  logic [3:0]     next_en;
  logic [5:0]     center_tap;

  // Lowest enabled link index >= from; bit 3 set means there is none.
  function automatic logic [3:0] find_en(input logic [NCH-1:0] en, input logic [3:0] from);
    logic [3:0] r;
    r = 4'b1000;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (en[i] && (4'(i) >= from)) r = 4'(i);
    end
    return r;
  endfunction

  assign first_en   = find_en(en_q, {1'b0, cur_ch});
  assign next_en    = find_en(en_q, {1'b0, cur_ch} + 4'd1);
  // 7-bit sum so a 60..63 eye centres on 61 rather than wrapping.
  assign center_tap = 6'((7'(eye_start) + 7'(eye_end)) >> 1);

  // Select the strobe bit, valid and data word of the link under training.
  always_comb begin
    ch_onehot = '0;
    valid_sel = 1'b0;
    data_sel  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (cur_ch == 3'(i)) begin
        ch_onehot[i] = 1'b1;
        valid_sel    = cout_valid_i[i];
        data_sel     = cout_data_i[32*i +: 32];
      end
    end
  end

  // Judge the current CHECK cycle: invalid cycles only advance the timeout.
  always_comb begin
    check_done = 1'b0;
    check_ok   = 1'b0;
    if (valid_sel) begin
      if (data_sel == TRAIN_SEQUENCE) begin
        if (match_cnt == LOCK_LAST) begin
          check_done = 1'b1;
          check_ok   = 1'b1;
        end
      end else begin
        check_done = 1'b1;
      end
    end else if (timer == '0) begin
      check_done = 1'b1;
    end
  end

  // Training sequencer.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= S_IDLE;
      phase     <= PH_SEARCH;
      cur_ch    <= '0;
      en_q      <= '0;
      tap       <= '0;
      slip      <= '0;
      eye_start <= '0;
      eye_end   <= '0;
      timer     <= '0;
      match_cnt <= '0;
      chk_pass  <= 1'b0;
      done_q    <= 1'b0;
      locked_q  <= '0;
      fail_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            locked_q <= '0;
            fail_q   <= '0;
            cur_ch   <= '0;
            tap      <= '0;
            slip     <= '0;
            phase    <= PH_SEARCH;
            en_q     <= ch_enable_i;
            if (ch_enable_i == '0) begin
              done_q <= 1'b1;
            end else begin
              state <= S_SRST;
              timer <= SRST_LD;
            end
          end
        end
        S_SRST: begin
          if (timer == '0) begin
            if (first_en[3]) begin
              done_q <= 1'b1;
              state  <= S_IDLE;
            end else begin
              cur_ch <= first_en[2:0];
              slip   <= '0;
              state  <= S_LOAD;
            end
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_LOAD: begin
          state <= S_WAIT;
          timer <= SETTLE_LD;
        end
        S_WAIT: begin
          if (timer == '0) begin
            state     <= S_CHECK;
            timer     <= TIMEOUT_LD;
            match_cnt <= '0;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_CHECK: begin
          if (check_done) begin
            chk_pass <= check_ok;
            if (phase == PH_EYE) begin
              state <= S_EYE;
            end else if (phase == PH_VERIFY) begin
              state <= S_VERIFY;
            end else if (check_ok) begin
              eye_start <= tap;
              eye_end   <= tap;
              if (tap == TAP_MAX) begin
                state <= S_CENTER;
              end else begin
                tap   <= tap + 6'd1;
                phase <= PH_EYE;
                state <= S_LOAD;
              end
            end else if (slip != SLIP_LAST) begin
              state <= S_SLIP;
            end else if (tap == TAP_MAX) begin
              fail_q <= fail_q | ch_onehot;
              state  <= S_NEXT;
            end else begin
              // Bitslip only moves forward, so go back to slip 0 via ISERDES reset.
              tap   <= tap + 6'd1;
              state <= S_SRST;
              timer <= SRST_LD;
            end
          end else if (valid_sel) begin
            timer     <= TIMEOUT_LD;
            match_cnt <= match_cnt + 16'd1;
          end else begin
            timer <= timer - 16'd1;
          end
        end
        S_SLIP: begin
          slip  <= slip + 8'd1;
          state <= S_WAIT;
          timer <= SETTLE_LD;
        end
        S_EYE: begin
          if (chk_pass) begin
            eye_end <= tap;
            if (tap == TAP_MAX) begin
              state <= S_CENTER;
            end else begin
              tap   <= tap + 6'd1;
              state <= S_LOAD;
            end
          end else begin
            state <= S_CENTER;
          end
        end
        S_CENTER: begin
          tap   <= center_tap;
          phase <= PH_VERIFY;
          state <= S_LOAD;
        end
        S_VERIFY: begin
          if (chk_pass) locked_q <= locked_q | ch_onehot;
          else          fail_q   <= fail_q | ch_onehot;
          state <= S_NEXT;
        end
        S_NEXT: begin
          if (next_en[3]) begin
            done_q <= 1'b1;
            state  <= S_IDLE;
          end else begin
            // Finished links keep their centred tap: they are never strobed again.
            cur_ch <= next_en[2:0];
            tap    <= '0;
            slip   <= '0;
            phase  <= PH_SEARCH;
            state  <= S_LOAD;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode straight from registered state, so reset clears them at once.
  always_comb begin
    iserdes_rst_o  = (state == S_SRST);
    idelay_value_o = tap;
    idelay_load_o  = (state == S_LOAD) ? ch_onehot : '0;
    bitslip_o      = (state == S_SLIP) ? ch_onehot : '0;
    busy_o         = (state != S_IDLE);
    done_o         = done_q;
    locked_o       = locked_q;
    fail_o         = fail_q;
    cur_ch_o       = cur_ch;
  end

endmodule

// File: tb/tb_surf_autotrain_seq.sv
// Bench for surf_autotrain_seq: two links, each modelled as an IDELAY tap
// register plus a bitslip counter, returning the training word only inside
// a configured tap window at one slip position.
module tb_surf_autotrain_seq;

  localparam int          NCH        = 2;
  localparam int          NSLIP      = 4;
  localparam int          SETTLE     = 4;
  localparam int          LOCK_COUNT = 4;
  localparam int          TIMEOUT    = 16;
  localparam logic [31:0] TRAIN      = 32'hA55A6996;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              start_i = 1'b0;
  logic [NCH-1:0]    ch_enable_i = '0;
  logic [32*NCH-1:0] cout_data_i = '0;
  logic [NCH-1:0]    cout_valid_i = '0;
  logic              iserdes_rst_o;
  logic [5:0]        idelay_value_o;
  logic [NCH-1:0]    idelay_load_o;
  logic [NCH-1:0]    bitslip_o;
  logic              busy_o;
  logic              done_o;
  logic [NCH-1:0]    locked_o;
  logic [NCH-1:0]    fail_o;
  logic [2:0]        cur_ch_o;

  surf_autotrain_seq #(
    .NCH(NCH), .TRAIN_SEQUENCE(TRAIN), .NSLIP(NSLIP), .SETTLE(SETTLE),
    .LOCK_COUNT(LOCK_COUNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn), .start_i(start_i), .ch_enable_i(ch_enable_i),
    .cout_data_i(cout_data_i), .cout_valid_i(cout_valid_i),
    .iserdes_rst_o(iserdes_rst_o), .idelay_value_o(idelay_value_o),
    .idelay_load_o(idelay_load_o), .bitslip_o(bitslip_o), .busy_o(busy_o),
    .done_o(done_o), .locked_o(locked_o), .fail_o(fail_o), .cur_ch_o(cur_ch_o)
  );

  always #5 aclk = ~aclk;

  // link model and monitors
  int   lo[NCH], hi[NCH], gs[NCH];
  logic novalid[NCH];
  int   tap_m[NCH], slip_m[NCH], bs_cnt[NCH], load_cnt[NCH];
  int   srst_cnt, done_cnt, viol;
  logic prev_rst = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  always @(negedge aclk) begin
    for (int n = 0; n < NCH; n++) begin
      if (iserdes_rst_o) slip_m[n] = 0;
      if (idelay_load_o[n]) begin
        tap_m[n] = int'(idelay_value_o);
        load_cnt[n]++;
      end
      if (bitslip_o[n]) begin
        slip_m[n] = (slip_m[n] + 1) % NSLIP;
        bs_cnt[n]++;
      end
    end
    if (iserdes_rst_o && !prev_rst) srst_cnt++;
    prev_rst = iserdes_rst_o;
    if (done_o) done_cnt++;
    if ($countones(idelay_load_o) > 1 || $countones(bitslip_o) > 1 || (locked_o & fail_o) != '0)
      viol++;
    for (int n = 0; n < NCH; n++) begin
      cout_valid_i[n] = !novalid[n];
      cout_data_i[32*n +: 32] = (tap_m[n] >= lo[n] && tap_m[n] <= hi[n] && slip_m[n] == gs[n])
                                ? TRAIN : (TRAIN ^ 32'h0000_0100);
    end
  end

  typedef struct {
    logic [1:0] en;
    int lo0, hi0, gs0, lo1, hi1, gs1;
    logic [1:0] exp_locked, exp_fail;
    int exp_tap0, exp_tap1, exp_bs0, exp_bs1, exp_srst;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int n = 0; n < NCH; n++) begin
      tap_m[n] = 0; slip_m[n] = 0; bs_cnt[n] = 0; load_cnt[n] = 0;
    end
    srst_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge aclk) start_i = 1'b1;
    @(negedge aclk) start_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done_o && k < budget) begin
      @(negedge aclk);
      k++;
    end
    if (!done_o) check("done_wait_expired", 0, 1);
  endtask

  task automatic wait_load(input int budget, input int tapv);
    int k = 0;
    while (!(idelay_load_o != '0 && (tapv < 0 || int'(idelay_value_o) == tapv)) && k < budget) begin
      @(negedge aclk);
      k++;
    end
    if (k >= budget) check("load_wait_expired", 0, 1);
  endtask

  function automatic int all_outs();
    return int'({iserdes_rst_o, idelay_value_o, idelay_load_o, bitslip_o, busy_o,
                 done_o, locked_o, fail_o, cur_ch_o});
  endfunction

  initial begin
    int k;
    for (int n = 0; n < NCH; n++) begin
      lo[n] = 1; hi[n] = 0; gs[n] = 0; novalid[n] = 1'b0;
    end
    viol = 0;
    clear_model();

    //            en     lo0 hi0 gs0 lo1 hi1 gs1 lock   fail   tap0 tap1 bs0  bs1  srst
    vecs[0] = '{2'b11, 10, 20, 2, 10, 20, 2, 2'b11, 2'b00, 15,  15,  32,  32,  21};
    vecs[1] = '{2'b11, 10, 20, 2,  1,  0, 0, 2'b01, 2'b10, 15,  63,  32,  192, 74};
    vecs[2] = '{2'b01, 60, 63, 0,  1,  0, 0, 2'b01, 2'b00, 61,  0,   180, 0,   61};
    vecs[3] = '{2'b10,  1,  0, 0,  0,  5, 1, 2'b10, 2'b00, 0,   2,   0,   1,   1};
    vecs[4] = '{2'b01, 63, 63, 3,  1,  0, 0, 2'b01, 2'b00, 63,  0,   192, 0,   64};
    vecs[5] = '{2'b10,  1,  0, 0,  7,  7, 0, 2'b10, 2'b00, 0,   7,   0,   21,  8};

    // reset state
    repeat (3) @(negedge aclk);
    check("reset_outputs", all_outs(), 0);
    aresetn = 1'b1;
    @(negedge aclk);
    check("idle_outputs", all_outs(), 0);

    // no links enabled: done the cycle after start, nothing else happens
    ch_enable_i = 2'b00;
    clear_model();
    @(negedge aclk) start_i = 1'b1;
    @(negedge aclk) start_i = 1'b0;
    check("noen_done", int'(done_o), 1);
    check("noen_busy", int'(busy_o), 0);
    @(negedge aclk);
    check("noen_done_pulse", int'(done_o), 0);
    repeat (5) @(negedge aclk);
    check("noen_srst", srst_cnt, 0);
    check("noen_strobes", load_cnt[0] + load_cnt[1] + bs_cnt[0] + bs_cnt[1], 0);
    check("noen_done_cnt", done_cnt, 1);

    // full training runs
    for (int v = 0; v < 6; v++) begin
      lo[0] = vecs[v].lo0; hi[0] = vecs[v].hi0; gs[0] = vecs[v].gs0;
      lo[1] = vecs[v].lo1; hi[1] = vecs[v].hi1; gs[1] = vecs[v].gs1;
      ch_enable_i = vecs[v].en;
      clear_model();
      pulse_start();
      wait_done(20000);
      repeat (3) @(negedge aclk);
      check($sformatf("v%0d_locked", v), int'(locked_o), int'(vecs[v].exp_locked));
      check($sformatf("v%0d_fail", v), int'(fail_o), int'(vecs[v].exp_fail));
      check($sformatf("v%0d_tap0", v), tap_m[0], vecs[v].exp_tap0);
      check($sformatf("v%0d_tap1", v), tap_m[1], vecs[v].exp_tap1);
      check($sformatf("v%0d_bitslips0", v), bs_cnt[0], vecs[v].exp_bs0);
      check($sformatf("v%0d_bitslips1", v), bs_cnt[1], vecs[v].exp_bs1);
      check($sformatf("v%0d_srst", v), srst_cnt, vecs[v].exp_srst);
      check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
      check($sformatf("v%0d_busy", v), int'(busy_o), 0);
    end

    // valid held low: each check gives up after exactly TIMEOUT cycles
    lo[0] = 1; hi[0] = 0; novalid[0] = 1'b1;
    ch_enable_i = 2'b01;
    clear_model();
    pulse_start();
    wait_load(100, -1);
    k = 0;
    do begin
      @(negedge aclk);
      k++;
    end while (bitslip_o[0] == 1'b0 && k < 200);
    check("timeout_len_after_load", k, 1 + SETTLE + TIMEOUT);
    k = 0;
    do begin
      @(negedge aclk);
      k++;
    end while (bitslip_o[0] == 1'b0 && k < 200);
    check("timeout_len_after_slip", k, 1 + SETTLE + TIMEOUT);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    novalid[0] = 1'b0;
    check("timeout_abort_outputs", all_outs(), 0);

    // reset during the eye scan, then retrain from scratch
    lo[0] = 10; hi[0] = 20; gs[0] = 2;
    ch_enable_i = 2'b01;
    clear_model();
    pulse_start();
    wait_load(3000, 12);
    @(negedge aclk);
    aresetn = 1'b0;
    @(negedge aclk);
    check("eye_reset_outputs", all_outs(), 0);
    @(negedge aclk);
    aresetn = 1'b1;
    repeat (20) @(negedge aclk);
    check("eye_reset_no_done", done_cnt, 0);
    check("eye_reset_idle", int'(busy_o), 0);
    clear_model();
    pulse_start();
    wait_load(100, -1);
    check("retrain_first_tap", int'(idelay_value_o), 0);
    pulse_start();
    wait_done(5000);
    repeat (3) @(negedge aclk);
    check("retrain_locked", int'(locked_o), 1);
    check("retrain_fail", int'(fail_o), 0);
    check("retrain_tap0", tap_m[0], 15);
    check("retrain_done_cnt", done_cnt, 1);

    check("strobe_onehot_exclusive", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/surf_autotrain_seq.md
SURF_AUTOTRAIN_SEQ -- requirements
Module: surf_autotrain_seq

Parameters
REQ-001 SHALL have parameter NCH, default 8, meaning number of SURF COUT links trained (1..8).
REQ-002 SHALL have parameter TRAIN_SEQUENCE, default 32'hA55A6996, meaning the expected aligned COUT training word.
REQ-003 SHALL have parameter NSLIP, default 4, meaning bitslip positions tried per delay tap.
REQ-004 SHALL have parameter SETTLE, default 16, meaning wait cycles after any delay load or bitslip.
REQ-005 SHALL have parameter LOCK_COUNT, default 8, meaning consecutive matching valid words for a pass.
REQ-006 SHALL have parameter TIMEOUT, default 256, meaning cycles without cout_valid before a check fails.

Interface
REQ-007 SHALL have port aclk, input, 1, the single clock for all logic.
REQ-008 SHALL have port aresetn, input, 1, synchronous active-low reset.
REQ-009 SHALL have port start_i, input, 1, one-cycle pulse that begins a training run.
REQ-010 SHALL have port ch_enable_i, input, NCH, links to train; disabled links are skipped.
REQ-011 SHALL have port cout_data_i, input, 32*NCH, per-link captured word; link n is at bits [32n+31:32n].
REQ-012 SHALL have port cout_valid_i, input, NCH, per-link word valid.
REQ-013 SHALL have port iserdes_rst_o, output, 1, ISERDES reset.
REQ-014 SHALL have port idelay_value_o, output, 6, tap value shared by all links.
REQ-015 SHALL have port idelay_load_o, output, NCH, one-hot load strobe.
REQ-016 SHALL have port bitslip_o, output, NCH, one-hot bitslip strobe.
REQ-017 SHALL have port busy_o, output, 1, high while a run is in progress.
REQ-018 SHALL have port done_o, output, 1, one-cycle pulse at the end of a run.
REQ-019 SHALL have port locked_o, output, NCH, per-link trained flag.
REQ-020 SHALL have port fail_o, output, NCH, per-link failed flag.
REQ-021 SHALL have port cur_ch_o, output, 3, index of the link being trained.

Function
REQ-022 SHALL implement states IDLE, SRST, LOAD, WAIT, CHECK, SLIP, EYE, CENTER, VERIFY, NEXT.
REQ-023 SHALL behave as follows in IDLE: start_i -> SRST, clear locked_o/fail_o, cur_ch=0; start_i while busy_o is ignored.
REQ-024 SHALL assert iserdes_rst_o for 4 cycles in SRST, then advance to the first enabled link at or after cur_ch, entering LOAD with tap=0 and slip=0.
REQ-025 SHALL pulse idelay_load_o[cur_ch] for exactly 1 cycle in LOAD with idelay_value_o stable, then enter WAIT.
REQ-026 SHALL hold WAIT for SETTLE cycles, then enter CHECK.
REQ-027 SHALL count matching valid words in CHECK; a pass is LOCK_COUNT consecutive matches; any mismatching valid word, or TIMEOUT cycles without valid, is a fail; invalid cycles neither count nor reset the match counter.
REQ-028 SHALL handle a CHECK pass during search by recording eye_start=tap and the slip, then setting tap+1 and entering EYE via LOAD/WAIT/CHECK.
REQ-029 SHALL handle a CHECK fail during search with slip<NSLIP-1 by entering SLIP: pulse bitslip_o[cur_ch] 1 cycle, slip+1, WAIT, CHECK.
REQ-030 SHALL handle a CHECK fail during search with slip=NSLIP-1 by setting tap+1; ISERDES is reset in SRST to restore slip 0 before LOAD.
REQ-031 SHALL handle a CHECK fail during search with tap=63 by setting fail_o[cur_ch] and going to NEXT.
REQ-032 SHALL, in EYE phase, step tap with slip held; eye_end = last passing tap; first fail or tap=63 pass ends the eye.
REQ-033 SHALL load tap=(eye_start+eye_end)>>1 (7-bit sum, floor) in CENTER, then WAIT and CHECK as VERIFY.
REQ-034 SHALL, on VERIFY, set locked_o[cur_ch] on pass and fail_o[cur_ch] on fail.
REQ-035 SHALL, in NEXT, go to the next enabled link or, if none remain, pulse done_o and return to IDLE.
REQ-036 SHALL keep the centred tap applied in the IDELAY of each finished link.
REQ-037 SHALL keep locked_o and fail_o mutually exclusive per link and hold them until the next start_i.
REQ-038 SHALL leave disabled links with locked_o=0 and fail_o=0; if no links are enabled, pulse done_o 1 cycle after start_i, with no SRST.
REQ-039 SHALL keep strobe outputs (idelay_load_o, bitslip_o) one-hot or zero at all times.

Reset
REQ-040 SHALL force, when aresetn=0 at a clock edge, state=IDLE and all outputs 0: iserdes_rst_o, idelay_value_o, idelay_load_o, bitslip_o, busy_o, done_o, locked_o, fail_o, cur_ch_o; all counters 0.
REQ-041 SHALL abort a run when reset is asserted mid-run, with no done_o.

Verification
REQ-042 SHALL pass scenario: NCH=2, both enabled, link model passes taps 10..20 at slip 2 -> bitslips 2 at tap 10, final load tap 15, locked_o=2'b11, done_o once.
REQ-043 SHALL pass scenario: link 1 never matches -> fail_o[1]=1, locked_o[1]=0, after trying 64 taps x NSLIP slips.
REQ-044 SHALL pass scenario: ch_enable_i=0 -> done_o 1 cycle after start_i, no strobes, no iserdes_rst_o.
REQ-045 SHALL pass scenario: cout_valid_i held low -> CHECK exits after exactly TIMEOUT cycles as a fail.
REQ-046 SHALL pass scenario: eye at taps 60..63 -> eye_end=63, center tap 61.
REQ-047 SHALL pass scenario: aresetn low during EYE -> next cycle all outputs 0, no done_o; a following start_i retrains from tap 0.
